nibble_serial_adder_ctrl: RTL



---
 rtl/nibble_serial_adder_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial WIDTH-bit adder: one shared 4-bit ripple-carry adder, LSB nibble first,
// with the carry held in a register between nibbles and valid/ready on both sides.

module ripple_carry_adder_4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_carry_in,
    output logic [3:0] o_s,
    output logic       o_carry_out
);
    logic [4:0] carry;

    assign carry[0] = i_carry_in;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign o_s[i]       = i_a[i] ^ i_b[i] ^ carry[i];
        assign carry[i + 1] = (i_a[i] & i_b[i]) | (carry[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_carry_out = carry[4];
endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry_in,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_s,
    output logic             o_carry_out,
    output logic             o_busy
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic              carry_q;
    logic [WIDTH-1:0]  a_q, b_q, s_q;
    logic              cout_q;

    logic [3:0]        a_nib [NIBBLES];
    logic [3:0]        b_nib [NIBBLES];
    logic [3:0]        add_s;
    logic              add_cout;
    logic              last;

    for (genvar k = 0; k < NIBBLES; k++) begin : g_nib
        assign a_nib[k] = a_q[4*k +: 4];
        assign b_nib[k] = b_q[4*k +: 4];
    end

    // Adder always sees registered operands, so its inputs are defined in every state.
    ripple_carry_adder_4 u_adder (
        .i_a         (a_nib[cnt]),
        .i_b         (b_nib[cnt]),
        .i_carry_in  (carry_q),
        .o_s         (add_s),
        .o_carry_out (add_cout)
    );

    assign last = (cnt == LAST);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_nx;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        o_ready  = 1'b0;
        o_busy   = 1'b0;
        o_valid  = 1'b0;
        unique case (state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_nx = S_ADD;
            end
            S_ADD: begin
                o_busy = 1'b1;
                if (last) state_nx = S_DONE;
            end
            S_DONE: begin
                o_valid = 1'b1;
                if (i_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: operand and result registers are reset too, so nothing is X after reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        a_q     <= i_a;
                        b_q     <= i_b;
                        carry_q <= i_carry_in;
                        s_q     <= '0;
                        cnt     <= '0;
                    end
                end
                S_ADD: begin
                    s_q[int'(cnt)*4 +: 4] <= add_s;
                    carry_q               <= add_cout;
                    if (last) begin
                        cout_q <= add_cout;
                        cnt    <= '0;
                    end else begin
                        cnt    <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_s         = s_q;
    assign o_carry_out = cout_q;
endmodule
